// File: rtl/mme_result_writer.sv
// mme_result_writer: snapshots a saturated accumulator tile and writes it to memory as one AXI INCR burst per row
module mme_result_writer #(
    parameter int DW       = 32,
    parameter int SA_WIDTH = 4
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start_i,
    input  logic signed [SA_WIDTH-1:0][SA_WIDTH-1:0][2*DW:0] accum_i,
    input  logic [31:0]                                   tile_addr_i,
    input  logic [7:0]                                    mat_width_i,
    output logic                                          busy_o,
    output logic                                          done_o,
    output logic                                          err_o,
    output logic                                          awvalid_o,
    input  logic                                          awready_i,
    output logic [31:0]                                   awaddr_o,
    output logic [3:0]                                    awlen_o,
    output logic [2:0]                                    awsize_o,
    output logic [1:0]                                    awburst_o,
    output logic                                          wvalid_o,
    input  logic                                          wready_i,
    output logic [DW-1:0]                                 wdata_o,
    output logic [DW/8-1:0]                               wstrb_o,
    output logic                                          wlast_o,
    input  logic                                          bvalid_i,
    output logic                                          bready_o,
    input  logic [1:0]                                    bresp_i
);
    localparam int RW = (SA_WIDTH > 1) ? $clog2(SA_WIDTH) : 1;
    localparam logic [RW-1:0] LAST = RW'(SA_WIDTH - 1);
    localparam logic signed [2*DW:0] MAX = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [2*DW:0] MIN = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

    state_t        r_state, w_next;
    logic [DW-1:0] r_snap [SA_WIDTH][SA_WIDTH];
    logic [31:0]   r_stride, r_awaddr;
    logic [RW-1:0] r_row, r_beat;
    logic [DW-1:0] r_wdata;
    logic          r_err, r_awvalid, r_wvalid, r_wlast, r_bready;
    logic          w_start, w_aw_hs, w_w_hs, w_b_hs, w_last_beat, w_last_row;
    logic [RW-1:0] w_beat_nx;

    function automatic logic [DW-1:0] sat(input logic signed [2*DW:0] v);
        return (v > MAX) ? {1'b0, {(DW-1){1'b1}}} : (v < MIN) ? {1'b1, {(DW-1){1'b0}}} : v[DW-1:0];
    endfunction

    assign w_start     = (r_state == IDLE) && start_i;
    assign w_aw_hs     = r_awvalid && awready_i;
    assign w_w_hs      = r_wvalid && wready_i;
    assign w_b_hs      = r_bready && bvalid_i;
    assign w_last_beat = r_beat == LAST;
    assign w_last_row  = r_row == LAST;
    assign w_beat_nx   = r_beat + 1'b1;

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (start_i ? AW : IDLE)
               : (r_state == AW)   ? (w_aw_hs ? W : AW)
               : (r_state == W)    ? ((w_w_hs && w_last_beat) ? B : W)
               :                     (w_b_hs ? (w_last_row ? IDLE : AW) : B);
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_wlast   <= 1'b0;
            r_err     <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_stride  <= '0;
            r_row     <= '0;
            r_beat    <= '0;
        end else begin
            r_awvalid <= w_next == AW;
            r_wvalid  <= w_next == W;
            r_bready  <= w_next == B;
            if (w_start) begin
                r_stride <= 32'(mat_width_i) * 32'(DW/8);
                r_awaddr <= tile_addr_i;
                r_row    <= '0;
                r_err    <= 1'b0;
            end
            if (w_aw_hs) begin
                r_beat  <= '0;
                r_wdata <= r_snap[r_row][0];
                r_wlast <= SA_WIDTH == 1;
            end
            if (w_w_hs && !w_last_beat) begin
                r_beat  <= w_beat_nx;
                r_wdata <= r_snap[r_row][w_beat_nx];
                r_wlast <= w_beat_nx == LAST;
            end
            if (w_b_hs) begin
                r_err <= r_err | (bresp_i != 2'b00);
                if (!w_last_row) begin
                    r_row    <= r_row + 1'b1;
                    r_awaddr <= r_awaddr + r_stride;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_start)
            for (int r = 0; r < SA_WIDTH; r++)
                for (int c = 0; c < SA_WIDTH; c++)
                    r_snap[r][c] <= sat(accum_i[r][c]);
    end

    assign done_o    = (r_state == B) && bvalid_i && w_last_row;
    assign busy_o    = (r_state != IDLE) && !done_o;
    assign err_o     = r_err;
    assign awvalid_o = r_awvalid;
    assign awaddr_o  = r_awaddr;
    assign awlen_o   = 4'(SA_WIDTH - 1);
    assign awsize_o  = 3'($clog2(DW/8));
    assign awburst_o = 2'b01;
    assign wvalid_o  = r_wvalid;
    assign wdata_o   = r_wdata;
    assign wstrb_o   = '1;
    assign wlast_o   = r_wlast;
    assign bready_o  = r_bready;
endmodule

// File: doc/mme_result_writer.md
# mme_result_writer

Write-back stage of the matrix-multiply engine, placed directly downstream of the MM engine. When the MM engine finishes a tile, this block snapshots the SA_WIDTH×SA_WIDTH signed accumulator array. It saturates each element to DW bits and writes the tile to matrix C in memory, one AXI write burst per tile row. It then reports completion and any write-response error back to the DMA/CFG control path.

## Interface
Parameters:
- DW, 32: element width in bits; also the AXI data width.
- SA_WIDTH, 4: systolic array width; this is the tile rows, the elements per row and the beats per burst.

Ports:
- clk  in  1  single clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle pulse from the MM engine (mm_done); starts a tile write-back.
- accum_i  in  signed [2*DW:0] [SA_WIDTH][SA_WIDTH]  accumulator array, indexed [row][col]; sampled only in the start cycle.
- tile_addr_i  in  32  byte address of tile element (0,0) in matrix C; sampled at start.
- mat_width_i  in  8  matrix width in elements, used as the row stride; sampled at start.
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle pulse when the last B response of the tile is accepted.
- err_o  out  1  sticky; set by any bresp != 2'b00; cleared by an accepted start or by rst.
- awvalid_o  out  1  AW valid.
- awready_i  in  1  AW ready.
- awaddr_o  out  32  burst start address.
- awlen_o  out  4  fixed at SA_WIDTH-1.
- awsize_o  out  3  fixed at log2(DW/8).
- awburst_o  out  2  fixed at 2'b01 (INCR).
- wvalid_o  out  1  W valid.
- wready_i  in  1  W ready.
- wdata_o  out  DW  write data beat.
- wstrb_o  out  DW/8  all ones.
- wlast_o  out  1  high on the last beat of a burst.
- bvalid_i  in  1  B valid.
- bready_o  out  1  B ready.
- bresp_i  in  2  write response.

## Operation
- States are IDLE, AW, W, B.
- IDLE:
  - start_i=1 captures the saturated accumulators into an internal SA_WIDTH×SA_WIDTH×DW register array.
  - It also captures tile_addr_i and the stride (mat_width_i×DW/8 bytes), sets row=0 and clears err_o.
  - Next state is AW.
- AW: awvalid_o=1 with awaddr_o = base + row×stride, computed mod 2^32. On awready_i → W, with beat=0.
- W:
  - wvalid_o=1 and wdata_o = snapshot[row][beat].
  - wlast_o = (beat==SA_WIDTH-1).
  - On wready_i, beat increments; the handshake on the last beat moves to B.
- B:
  - bready_o=1.
  - On bvalid_i, err_o |= (bresp_i!=0).
  - If row==SA_WIDTH-1, pulse done_o and go to IDLE; otherwise row++ and go to AW.
- Saturation of each element, with MAX = 2^(DW-1)-1 and MIN = -2^(DW-1):
  - value > MAX gives MAX.
  - value < MIN gives MIN.
  - otherwise the low DW bits.
- Writes are strictly serialized: AW precedes its W beats, and at most one burst is outstanding.
- Error responses do not abort the tile; all SA_WIDTH rows are always written.
- start_i while busy is ignored: no re-capture, and err_o is not cleared.
- mat_width_i=0 is legal; every row then writes to tile_addr_i.

## Timing
- Reset values:
  - State is IDLE.
  - busy_o, done_o, err_o, awvalid_o, wvalid_o, wlast_o and bready_o are 0.
  - awaddr_o and wdata_o are 0.
  - The fixed fields (awlen_o, awsize_o, awburst_o, wstrb_o) always drive their constants.
- rst mid-operation returns to IDLE next cycle with all valids low. Any in-flight AXI transaction is abandoned; the system must reset the interconnect too.
- Start at cycle 0 → busy_o=1 and awvalid_o=1 at cycle 1.
- Valids are registered outputs. Once asserted, awvalid_o/wvalid_o and their payloads hold stable until the handshake; they never depend combinationally on ready.
- The W beat after the AW handshake is presented the next cycle. Consecutive beats can handshake back-to-back, one per cycle, while wready_i=1.
- bready_o is asserted the cycle after the last-beat handshake.
- With all readies/bvalid tied high, one row takes 1 (AW) + SA_WIDTH (W) + 1 (B) cycles. For SA_WIDTH=4 this is 6 cycles per row. done_o fires at cycle 24 after start, and busy_o falls in the same cycle as done_o.
- A start pulse in the done_o cycle is ignored. The earliest accepted start is the cycle after done_o.

## Test plan
- Identity tile: accum[r][c]=r*4+c, tile_addr_i=0x1000, mat_width_i=16, all readies high.
  - Expect AW addresses 0x1000, 0x1040, 0x1080 and 0x10C0.
  - Expect W data 0..15 in row-major order, with wlast_o on beats 3, 7, 11 and 15.
  - Expect done_o at cycle 24 and err_o=0.
- Saturation: elements 2^40, -2^40, 2^31-1 and -2^31 written → 0x7FFFFFFF, 0x80000000, 0x7FFFFFFF, 0x80000000.
- Backpressure: random awready_i/wready_i/bvalid_i stalls up to 5 cycles.
  - awvalid_o/wvalid_o and their payloads stay stable until the handshake.
  - Exactly 4 AW and 16 W handshakes occur, and no W beat precedes its AW.
- Error: bresp_i=2'b10 on row 1 only.
  - All 4 rows are still written and err_o=1 after done_o.
  - The next accepted start clears err_o.
- Start while busy: second start_i pulse with different accum at cycle 10.
  - The pulse is ignored and data stays from the first snapshot.
  - A start pulsed in the cycle after done_o is accepted.
- Reset mid-burst: rst=1 during the W state, beat 2.
  - The next cycle is IDLE with all valids 0 and busy_o=0.
  - A subsequent start completes a normal tile.
